pipe_add_clk: RTL

//  Parametrised pipelined adder/subtractor; next generation of the registered adder.

---
 rtl/pipe_add_clk.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_add_clk.sv
// rtl/pipe_add_clk.sv - pipelined adder/subtractor, one carry segment per stage, valid/ready with stall.
// Optional signed-overflow output ovf is enabled by defining PIPE_ADD_OVF_EN.
module pipe_add_clk #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef PIPE_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);
    localparam int SEG = WIDTH / STAGES;

    // Index 0 is the operand capture stage; index STAGES drives the outputs.
    logic [WIDTH-1:0] a_q [STAGES+1];
    logic [WIDTH-1:0] a_d [STAGES+1];
    logic [WIDTH-1:0] b_q [STAGES+1];
    logic [WIDTH-1:0] b_d [STAGES+1];
    logic [WIDTH-1:0] r_q [STAGES+1];
    logic [WIDTH-1:0] r_d [STAGES+1];
    logic [STAGES:0]  c_q, c_d;
    logic [STAGES:0]  v_q, v_d;
    logic [SEG:0]     seg_sum;
    logic             adv;

    always_comb begin
        adv      = !v_q[STAGES] | out_ready;
        in_ready = adv & !rst;
        a_d[0]   = a;
        b_d[0]   = sub ? ~b : b;
        c_d[0]   = sub | ci;
        v_d[0]   = in_valid;
        r_d[0]   = '0;
        seg_sum  = '0;
        for (int k = 1; k <= STAGES; k++) begin
            seg_sum = {1'b0, a_q[k-1][(k-1)*SEG +: SEG]}
                    + {1'b0, b_q[k-1][(k-1)*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_q[k-1]};
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            v_d[k] = v_q[k-1];
            c_d[k] = seg_sum[SEG];
            r_d[k] = r_q[k-1];
            r_d[k][(k-1)*SEG +: SEG] = seg_sum[SEG-1:0];
        end
    end

    // The whole pipe, bubbles included, moves only when the output slot is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (adv) begin
            for (int k = 0; k <= STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign s         = r_q[STAGES];
    assign co        = c_q[STAGES];
    assign out_valid = v_q[STAGES];
`ifdef PIPE_ADD_OVF_EN
    assign ovf = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1])
               & (r_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);
`endif
endmodule
